// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the ID-stage immediate generator: opcodes, format
// codes and the occupancy encoding of the two-entry output buffer.
package imm_gen_pipe_pkg;

  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_32       = 7'b0111011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_Z   = 3'd6,
    FMT_INV = 3'd7
  } fmt_e;

  typedef enum logic [1:0] {
    SK_EMPTY = 2'd0,
    SK_ONE   = 2'd1,
    SK_TWO   = 2'd2
  } skid_e;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// Combinational RV32/RV64 immediate decoder: format class, sign-extended
// immediate and illegal flag straight from the instruction word.
module imm_decode
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_e            fmt,
  output logic            illegal
);

  logic [31:0] imm32;
  logic        unused_funct3;

  // funct3[1:0] never affects the immediate or format
  assign unused_funct3 = ^instr[13:12];

  always_comb begin
    fmt   = FMT_INV;
    imm32 = '0;
    case (instr[6:0])
      OP_LOAD, OP_MISC_MEM, OP_IMM, OP_JALR: fmt = FMT_I;
      OP_IMM_32: fmt = (XLEN == 64) ? FMT_I : FMT_INV;
      OP_STORE:  fmt = FMT_S;
      OP_BRANCH: fmt = FMT_B;
      OP_LUI, OP_AUIPC: fmt = FMT_U;
      OP_JAL:    fmt = FMT_J;
      OP_OP:     fmt = FMT_R;
      OP_32:     fmt = (XLEN == 64) ? FMT_R : FMT_INV;
      OP_SYSTEM: fmt = instr[14] ? FMT_Z : FMT_I;
      default:   fmt = FMT_INV;
    endcase
    if (instr[1:0] != 2'b11) fmt = FMT_INV;

    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'b0};
      FMT_J:   imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_Z:   imm32 = {27'b0, instr[19:15]};
      default: imm32 = '0;
    endcase
  end

  assign illegal = (fmt == FMT_INV);

  // zimm has bit 31 clear, so widening every format by bit 31 is safe
  if (XLEN == 64) begin : g_x64
    assign imm = {{32{imm32[31]}}, imm32};
  end else begin : g_x32
    assign imm = imm32;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// ID-stage immediate generator: decode at the input, then a 1- or 2-entry
// valid/ready buffer of decoded fields, flush, and a saturating illegal counter.
module imm_gen_pipe
  import imm_gen_pipe_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [XLEN-1:0]  out_pc,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_count
);

  logic [XLEN-1:0]  dec_imm;
  fmt_e             dec_fmt;
  logic             dec_ill;

  skid_e            st_q, st_d;
  logic [XLEN-1:0]  m_imm_q, m_imm_d, m_pc_q, m_pc_d;
  logic [XLEN-1:0]  s_imm_q, s_imm_d, s_pc_q, s_pc_d;
  fmt_e             m_fmt_q, m_fmt_d, s_fmt_q, s_fmt_d;
  logic             m_ill_q, m_ill_d, s_ill_q, s_ill_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc, pop;

  imm_decode #(.XLEN(XLEN)) u_dec (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_ill)
  );

  assign out_valid = (st_q != SK_EMPTY);

  if (SKID != 0) begin : g_skid
    assign in_ready = (st_q != SK_TWO);
  end else begin : g_noskid
    assign in_ready = !out_valid || out_ready;
  end

  assign acc = in_valid && in_ready && !flush;
  assign pop = out_valid && out_ready;

  always_comb begin
    st_d    = st_q;
    m_imm_d = m_imm_q;
    m_fmt_d = m_fmt_q;
    m_ill_d = m_ill_q;
    m_pc_d  = m_pc_q;
    s_imm_d = s_imm_q;
    s_fmt_d = s_fmt_q;
    s_ill_d = s_ill_q;
    s_pc_d  = s_pc_q;
    cnt_d   = cnt_q;

    if (flush) begin
      st_d = SK_EMPTY;
    end else begin
      case (st_q)
        SK_EMPTY: if (acc) begin
          st_d = SK_ONE;
          {m_imm_d, m_fmt_d, m_ill_d, m_pc_d} = {dec_imm, dec_fmt, dec_ill, in_pc};
        end
        SK_ONE: if (acc && pop) begin
          {m_imm_d, m_fmt_d, m_ill_d, m_pc_d} = {dec_imm, dec_fmt, dec_ill, in_pc};
        end else if (acc) begin
          // only reachable with SKID=1; SKID=0 accepts here only alongside a pop
          st_d = SK_TWO;
          {s_imm_d, s_fmt_d, s_ill_d, s_pc_d} = {dec_imm, dec_fmt, dec_ill, in_pc};
        end else if (pop) begin
          st_d = SK_EMPTY;
        end
        SK_TWO: if (pop) begin
          st_d = SK_ONE;
          {m_imm_d, m_fmt_d, m_ill_d, m_pc_d} = {s_imm_q, s_fmt_q, s_ill_q, s_pc_q};
        end
        default: st_d = SK_EMPTY;
      endcase
    end

    if (acc && dec_ill && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= SK_EMPTY;
      m_imm_q <= '0;
      m_fmt_q <= FMT_R;
      m_ill_q <= 1'b0;
      m_pc_q  <= '0;
      s_imm_q <= '0;
      s_fmt_q <= FMT_R;
      s_ill_q <= 1'b0;
      s_pc_q  <= '0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      m_imm_q <= m_imm_d;
      m_fmt_q <= m_fmt_d;
      m_ill_q <= m_ill_d;
      m_pc_q  <= m_pc_d;
      s_imm_q <= s_imm_d;
      s_fmt_q <= s_fmt_d;
      s_ill_q <= s_ill_d;
      s_pc_q  <= s_pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_imm       = m_imm_q;
  assign out_fmt       = m_fmt_q;
  assign out_pc        = m_pc_q;
  assign out_illegal   = m_ill_q;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench: instance a (XLEN=32, SKID=1, CNT_W=4) and instance b
// (XLEN=64, SKID=0, CNT_W=16) driven with directed, hand-decoded vectors.
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_flush = 0, a_in_valid = 0, a_out_ready = 0;
  logic [31:0] a_in_instr = 0, a_in_pc = 0;
  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [31:0] a_out_imm, a_out_pc;
  logic [2:0]  a_out_fmt;
  logic [3:0]  a_cnt;

  logic        b_flush = 0, b_in_valid = 0, b_out_ready = 0;
  logic [31:0] b_in_instr = 0;
  logic [63:0] b_in_pc = 0;
  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [63:0] b_out_imm, b_out_pc;
  logic [2:0]  b_out_fmt;
  logic [15:0] b_cnt;

  imm_gen_pipe #(.XLEN(32), .SKID(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_imm(a_out_imm),
    .out_fmt(a_out_fmt), .out_pc(a_out_pc), .out_illegal(a_out_illegal),
    .illegal_count(a_cnt)
  );

  imm_gen_pipe #(.XLEN(64), .SKID(0), .CNT_W(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_imm(b_out_imm),
    .out_fmt(b_out_fmt), .out_pc(b_out_pc), .out_illegal(b_out_illegal),
    .illegal_count(b_cnt)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [63:0] pc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int ncmp = 0;
  int nerr = 0;
  int expcnt_a = 0;
  int expcnt_b = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // monitors: pop the oldest expectation whenever the DUT transfers an entry
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n && !a_flush && a_out_valid && a_out_ready) begin
      if (qa.size() == 0) chk("a_spurious_out", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_imm", {32'b0, a_out_imm}, e.imm);
        chk("a_fmt", {61'b0, a_out_fmt}, {61'b0, e.fmt});
        chk("a_ill", {63'b0, a_out_illegal}, {63'b0, e.ill});
        chk("a_pc",  {32'b0, a_out_pc}, e.pc);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && !b_flush && b_out_valid && b_out_ready) begin
      if (qb.size() == 0) chk("b_spurious_out", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_imm", b_out_imm, e.imm);
        chk("b_fmt", {61'b0, b_out_fmt}, {61'b0, e.fmt});
        chk("b_ill", {63'b0, b_out_illegal}, {63'b0, e.ill});
        chk("b_pc",  b_out_pc, e.pc);
      end
    end
  end

  // drive one instruction into instance a (sel=0) or b (sel=1) until accepted
  task automatic send(input bit sel, input logic [31:0] ins, input logic [63:0] pc,
                      input logic [63:0] imm, input logic [2:0] fmt, input logic ill);
    exp_t e;
    e.imm = imm; e.fmt = fmt; e.ill = ill;
    e.pc  = sel ? pc : {32'b0, pc[31:0]};
    if (sel) begin b_in_valid = 1; b_in_instr = ins; b_in_pc = pc; end
    else begin a_in_valid = 1; a_in_instr = ins; a_in_pc = pc[31:0]; end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sel ? b_in_ready : a_in_ready) begin
        if (sel) begin
          qb.push_back(e);
          if (ill && expcnt_b < 65535) expcnt_b++;
        end else begin
          qa.push_back(e);
          if (ill && expcnt_a < 15) expcnt_a++;
        end
        @(posedge clk); #1;
        if (sel) b_in_valid = 0; else a_in_valid = 0;
        return;
      end
      @(posedge clk); #1;
    end
    chk(sel ? "b_accept_timeout" : "a_accept_timeout", 0, 1);
    if (sel) b_in_valid = 0; else a_in_valid = 0;
  endtask

  task automatic drain();
    for (int k = 0; k < 200; k++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_a_left", qa.size(), 0);
    chk("drain_b_left", qb.size(), 0);
  endtask

  initial begin
    #12;
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_imm", a_out_imm, 0);
    chk("rst_a_fmt", a_out_fmt, 0);
    chk("rst_a_pc", a_out_pc, 0);
    chk("rst_a_ill", a_out_illegal, 0);
    chk("rst_a_cnt", a_cnt, 0);
    chk("rst_a_ready", a_in_ready, 1);
    chk("rst_b_valid", b_out_valid, 0);
    chk("rst_b_ready", b_in_ready, 1);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // XLEN=64, SKID=0, back-to-back with a free-flowing sink
    b_out_ready = 1;
    send(1, 32'h800002B7, 64'h100, 64'hFFFF_FFFF_8000_0000, 3'd4, 0);
    chk("b_latency_valid", b_out_valid, 1);
    send(1, 32'h0010809B, 64'h104, 64'h1, 3'd1, 0);
    send(1, 32'h0000003B, 64'h108, 64'h0, 3'd0, 0);
    send(1, 32'hFFDFF06F, 64'h10C, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 0);
    send(1, 32'hFE20AC23, 64'h110, 64'hFFFF_FFFF_FFFF_FFF8, 3'd2, 0);
    send(1, 32'h00004501, 64'h114, 64'h0, 3'd7, 1);
    drain();
    chk("b_cnt", b_cnt, expcnt_b);
    b_out_ready = 0;
    send(1, 32'h00000013, 64'h118, 64'h0, 3'd1, 0);
    chk("b_ready_stalled", b_in_ready, 0);
    b_out_ready = 1; #1;
    chk("b_ready_comb", b_in_ready, 1);
    drain();

    // XLEN=32, SKID=1: decode vectors, first one held to check stability
    a_out_ready = 0;
    send(0, 32'hFE000EE3, 64'h200, 64'hFFFF_FFFC, 3'd3, 0);
    chk("a_latency_valid", a_out_valid, 1);
    @(negedge clk);
    chk("a_hold_pc", a_out_pc, 32'h200);
    chk("a_hold_imm", a_out_imm, 32'hFFFF_FFFC);
    @(posedge clk); #1; a_out_ready = 1;
    send(0, 32'h3002D073, 64'h204, 64'h5, 3'd6, 0);
    send(0, 32'h00000073, 64'h208, 64'h0, 3'd1, 0);
    send(0, 32'h0010809B, 64'h20C, 64'h0, 3'd7, 1);
    send(0, 32'h00000000, 64'h210, 64'h0, 3'd7, 1);
    drain();
    chk("a_cnt_2", a_cnt, expcnt_a);

    // backpressure: two fill main+skid, third waits
    a_out_ready = 0;
    send(0, 32'h00000013, 64'h0, 64'h0, 3'd1, 0);
    send(0, 32'h00000013, 64'h4, 64'h0, 3'd1, 0);
    chk("a_stall_ready", a_in_ready, 0);
    fork
      send(0, 32'h00000013, 64'h8, 64'h0, 3'd1, 0);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("a_stall_held_ready", a_in_ready, 0);
          chk("a_stall_head_pc", a_out_pc, 32'h0);
        end
        @(posedge clk); #1; a_out_ready = 1;
      end
    join
    drain();

    // flush with both entries full, input that cycle dropped
    a_out_ready = 0;
    send(0, 32'h00000013, 64'h20, 64'h0, 3'd1, 0);
    send(0, 32'h00000000, 64'h24, 64'h0, 3'd7, 1);
    a_flush = 1; a_in_valid = 1; a_in_instr = 32'h0;
    @(posedge clk); #1;
    a_flush = 0; a_in_valid = 0; qa.delete();
    chk("a_flush_valid", a_out_valid, 0);
    chk("a_flush_ready", a_in_ready, 1);
    chk("a_flush_cnt", a_cnt, expcnt_a);
    // flush while empty with an illegal input offered: must not be taken or counted
    a_flush = 1; a_in_valid = 1; a_in_instr = 32'h0;
    @(posedge clk); #1;
    a_flush = 0; a_in_valid = 0;
    chk("a_flush2_valid", a_out_valid, 0);
    chk("a_flush2_cnt", a_cnt, expcnt_a);
    a_out_ready = 1;
    repeat (3) @(posedge clk);
    #1;

    // saturation at 4'hF
    for (int i = 0; i < 20; i++)
      send(0, 32'h00000000, 64'h400 + 64'(i * 4), 64'h0, 3'd7, 1);
    drain();
    chk("a_cnt_sat_model", expcnt_a, 15);
    chk("a_cnt_sat", a_cnt, 4'hF);

    // asynchronous reset mid-stream
    a_out_ready = 0;
    send(0, 32'hFE000EE3, 64'h300, 64'hFFFF_FFFC, 3'd3, 0);
    #2; rst_n = 0; #1;
    qa.delete(); qb.delete(); expcnt_a = 0; expcnt_b = 0;
    chk("arst_a_valid", a_out_valid, 0);
    chk("arst_a_imm", a_out_imm, 0);
    chk("arst_a_fmt", a_out_fmt, 0);
    chk("arst_a_pc", a_out_pc, 0);
    chk("arst_a_ill", a_out_illegal, 0);
    chk("arst_a_cnt", a_cnt, 0);
    chk("arst_a_ready", a_in_ready, 1);
    chk("arst_b_cnt", b_cnt, 0);
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    a_out_ready = 1;
    send(0, 32'h00000073, 64'h500, 64'h0, 3'd1, 0);
    drain();
    chk("a_cnt_after_rst", a_cnt, expcnt_a);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
